// File: rtl/sram_req_arbiter.sv
// Shares one sram-like slave between the fetch and data masters, routing responses in order.
// Optional SRAM_ARB_ROUND_ROBIN_EN swaps fixed data priority for last-winner round robin.
module sram_req_arbiter #(
   parameter int OUTSTANDING = 2,
   parameter int IDW         = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic        sram_req,
   output logic        sram_wr,
   output logic [1:0]  sram_size,
   output logic [3:0]  sram_wstrb,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic        sram_addr_ok,
   input  logic        sram_data_ok,
   input  logic [31:0] sram_rdata,
   output logic        resp_err
);

   localparam logic [IDW:0] FULL_CNT = (IDW+1)'(OUTSTANDING);

   logic [OUTSTANDING-1:0] owner_q;
   logic [IDW-1:0]         wptr_q;
   logic [IDW-1:0]         rptr_q;
   logic [IDW:0]           cnt_q;
   logic                   err_q;

   logic full;
   logic grant_d;
   logic grant_i;
   logic push;
   logic pop;
   logic empty_pop;
   logic head;

   assign full = (cnt_q == FULL_CNT);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   // last_d_q = 1 means data won the last accepted handshake
   logic last_d_q;
   logic prefer_d;

   assign prefer_d = ~last_d_q;
   assign grant_d  = ~full & data_sram_req
                   & (~inst_sram_req | prefer_d);
   assign grant_i  = ~full & inst_sram_req
                   & (~data_sram_req | ~prefer_d);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_d_q <= 1'b0;
      end else if (push) begin
         last_d_q <= grant_d;
      end
   end
`else
   assign grant_d = ~full & data_sram_req;
   assign grant_i = ~full & inst_sram_req & ~data_sram_req;
`endif

   assign sram_req   = grant_d | grant_i;
   assign sram_wr    = grant_i ? inst_sram_wr    : data_sram_wr;
   assign sram_size  = grant_i ? inst_sram_size  : data_sram_size;
   assign sram_wstrb = grant_i ? inst_sram_wstrb : data_sram_wstrb;
   assign sram_addr  = grant_i ? inst_sram_addr  : data_sram_addr;
   assign sram_wdata = grant_i ? inst_sram_wdata : data_sram_wdata;

   assign data_sram_addr_ok = grant_d & sram_addr_ok;
   assign inst_sram_addr_ok = grant_i & sram_addr_ok;

   assign push      = sram_req & sram_addr_ok;
   assign pop       = sram_data_ok & (cnt_q != '0);
   assign empty_pop = sram_data_ok & (cnt_q == '0);
   assign head      = owner_q[rptr_q];

   assign inst_sram_data_ok = pop & ~head;
   assign data_sram_data_ok = pop & head;
   assign inst_sram_rdata   = sram_rdata;
   assign data_sram_rdata   = sram_rdata;
   assign resp_err          = err_q;

   // Pointers wrap naturally since OUTSTANDING is a power of two
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (push) begin
            owner_q[wptr_q] <= grant_d;
            wptr_q          <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (!push && pop) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (empty_pop) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one sram-like slave port (the cache/AXI bridge side) between the instruction-fetch master and the data-access master of the pipeline.
- Per-cycle arbitration on the request phase.
- Records the owner of every accepted request in an in-order ownership FIFO.
- Routes each data_ok/rdata response back to its owner in acceptance order.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered requests (ownership FIFO depth, power of two, ≥2)
- IDW, 1, ownership FIFO pointer width = log2(OUTSTANDING)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_sram_req  in  1  fetch request
- inst_sram_wr  in  1  fetch write flag (always 0 from IF, passed through)
- inst_sram_size  in  2  fetch size
- inst_sram_wstrb  in  4  fetch byte strobes
- inst_sram_addr  in  32  fetch address
- inst_sram_wdata  in  32  fetch write data
- inst_sram_addr_ok  out  1  fetch request accepted
- inst_sram_data_ok  out  1  fetch response valid
- inst_sram_rdata  out  32  fetch read data
- data_sram_req  in  1  data request
- data_sram_wr  in  1  data write flag
- data_sram_size  in  2  data size
- data_sram_wstrb  in  4  data byte strobes
- data_sram_addr  in  32  data address
- data_sram_wdata  in  32  data write data
- data_sram_addr_ok  out  1  data request accepted
- data_sram_data_ok  out  1  data response valid
- data_sram_rdata  out  32  data read data
- sram_req  out  1  slave request
- sram_wr  out  1  slave write flag
- sram_size  out  2  slave size
- sram_wstrb  out  4  slave byte strobes
- sram_addr  out  32  slave address
- sram_wdata  out  32  slave write data
- sram_addr_ok  in  1  slave accepted request
- sram_data_ok  in  1  slave response valid
- sram_rdata  in  32  slave read data
- resp_err  out  1  sticky: sram_data_ok arrived with ownership FIFO empty

Behaviour:
- Reset (async, resetn=0):
  - FIFO read/write pointers and count = 0.
  - resp_err = 0.
  - Round-robin pointer (if built) = data.
  - All outputs are combinational from state and inputs.
  - With no inputs active, every ok/req output is 0.
- Full: count == OUTSTANDING.
  - When full, sram_req = 0 and both *_addr_ok = 0, even if a pop occurs in the same cycle (no bypass).
- Grant, combinational, only when not full:
  - Fixed priority: data over inst.
  - grant_d = data_sram_req; grant_i = inst_sram_req & ~data_sram_req.
- Slave request:
  - sram_req = grant_d | grant_i.
  - sram_wr/size/wstrb/addr/wdata are muxed from the granted master; data fields are selected when neither is granted.
- Accept acknowledgement:
  - data_sram_addr_ok = grant_d & sram_addr_ok.
  - inst_sram_addr_ok = grant_i & sram_addr_ok.
  - A non-granted master sees addr_ok = 0 and must hold its request. Its fields may change; the arbiter stores nothing but the owner.
- Push: on sram_req & sram_addr_ok, write the owner bit (1 = data, 0 = inst) at the write pointer. Write pointer +1, wrapping at OUTSTANDING.
- Response routing:
  - On sram_data_ok with count > 0, the head owner is selected.
  - inst_sram_data_ok = sram_data_ok & ~head; data_sram_data_ok = sram_data_ok & head.
  - Both rdata outputs = sram_rdata unconditionally.
  - Read pointer +1 with wrap.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
  - The response belongs to the older entry.
  - A same-cycle accept+response with count = 0 is illegal from the slave. Treat it as an empty pop: set resp_err, drop the response, and still push.
- Empty pop: sram_data_ok with count = 0 sets resp_err (held until reset), drops the response, and leaves the pointers unchanged.
- Latency:
  - Zero added cycles on the request and response paths.
  - Ownership is registered one cycle after the accept, so a response can return at the earliest one cycle after its addr_ok.
- Reset mid-transaction discards all ownership. The slave and masters are reset together; stray responses afterwards set resp_err.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A one-bit last-winner register selects the priority: the master not granted last accept wins when both request.
  - The register updates only on an accepted handshake (sram_req & sram_addr_ok). Reset value gives data priority first.
- Undefined: fixed data-over-inst priority; no extra register.

Test Plan:
- Fetch only: inst_sram_req=1, addr 0xbfc00000; slave addr_ok in cycle 0, data_ok+rdata 0x3c1d8000 in cycle 2 -> inst_sram_addr_ok=1 in cycle 0, inst_sram_data_ok=1 with rdata 0x3c1d8000 in cycle 2, data_sram_*_ok stay 0.
- Contention: both request (inst 0xbfc00004, data load 0x80001000), slave always addr_ok -> sram_addr=0x80001000 first, data_sram_addr_ok=1. Next cycle inst granted (addr 0xbfc00004). Responses in order go to data then inst. With SRAM_ARB_ROUND_ROBIN_EN and a prior data win, inst wins first.
- Full: OUTSTANDING=2, two accepts, no data_ok -> third cycle sram_req=0 and both addr_ok=0. A data_ok then frees one slot, and the next cycle accepts.
- Wrap: 5 alternating inst/data accepts with one-cycle response lag -> every data_ok routed to the correct owner across pointer wrap; count never exceeds 2.
- Error/reset: sram_data_ok with empty FIFO -> resp_err=1 and both *_data_ok=0. Assert resetn=0 mid-burst with 1 outstanding -> count=0 and resp_err=0 immediately (async), and all ok outputs are 0.
